// File: rtl/picosoc_iotimer.sv
// picosoc_iotimer: memory-mapped down-counting timer on the iomem bus.
// Registered one-cycle ready, byte-strobed writes, live COUNT readback and
// a registered level interrupt. Define PICOSOC_IOTIMER_CAPTURE_EN to add
// the synchronised capture input (CAPTURE register and STATUS[1]).
module picosoc_iotimer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq_out,
  input  logic        capt_in
);

  // Word index inside the 256-byte window (addr[7:2]).
  typedef enum logic [5:0] {
    REG_CTRL     = 6'h00,
    REG_PRESCALE = 6'h01,
    REG_RELOAD   = 6'h02,
    REG_COUNT    = 6'h03,
    REG_STATUS   = 6'h04,
    REG_CAPTURE  = 6'h05
  } reg_e;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Architectural state
  logic [2:0]            ctrl_q,     ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           reload_q,   reload_d;
  logic [31:0]           count_q,    count_d;
  logic                  expired_q,  expired_d;
  logic [PRESCALE_W-1:0] pcnt_q,     pcnt_d;
  logic                  ready_q,    ready_d;
  logic [31:0]           rdata_q,    rdata_d;
  logic                  irq_q,      irq_d;

  // Bus decode
  logic       sel, wr, rd;
  logic [5:0] reg_idx;
  logic       status_w1c_0, status_w1c_1;

  // Timer control
  logic ctrl_en, ctrl_autoreload, ctrl_irqen;
  logic tick, count_wr, expire_set;

  // Capture-side values seen by the read mux and irq logic
  logic        captured_flag;
  logic [31:0] capture_val;

  assign ctrl_en         = ctrl_q[0];
  assign ctrl_autoreload = ctrl_q[1];
  assign ctrl_irqen      = ctrl_q[2];

  // Select excludes the ready cycle so a held valid is not accepted twice.
  assign sel     = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]) && !ready_q;
  assign wr      = sel && (iomem_wstrb != 4'b0000);
  assign rd      = sel && (iomem_wstrb == 4'b0000);
  assign reg_idx = iomem_addr[7:2];

  assign status_w1c_0 = wr && (reg_idx == REG_STATUS) && iomem_wstrb[0] && iomem_wdata[0];
  assign status_w1c_1 = wr && (reg_idx == REG_STATUS) && iomem_wstrb[0] && iomem_wdata[1];
  assign count_wr     = wr && (reg_idx == REG_COUNT);

  // Address bits [1:0] are ignored by the word-aligned map.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^iomem_addr[1:0];

  // Configuration register writes (CTRL, PRESCALE, RELOAD)
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    reload_d   = reload_q;
    if (wr) begin
      unique case (reg_idx)
        REG_CTRL: begin
          if (iomem_wstrb[0]) ctrl_d = iomem_wdata[2:0];
        end
        REG_PRESCALE: begin
          for (int i = 0; i < int'(PRESCALE_W); i++) begin
            if (iomem_wstrb[i/8]) prescale_d[i] = iomem_wdata[i];
          end
        end
        REG_RELOAD: reload_d = byte_merge(reload_q, iomem_wdata, iomem_wstrb);
        default: ;
      endcase
    end
  end

  // Prescaler: counts 0..PRESCALE while enabled; equality-only compare
  always_comb begin
    tick   = ctrl_en && (pcnt_q == prescale_q);
    pcnt_d = pcnt_q;
    if (!ctrl_en) begin
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = '0;
    end else if (pcnt_q > prescale_q) begin
      // PRESCALE was lowered under a running count: restart from zero.
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end
  end

  // Down counter and EXPIRED flag; a bus write to COUNT beats the tick
  always_comb begin
    count_d    = count_q;
    expire_set = 1'b0;
    if (count_wr) begin
      count_d = byte_merge(count_q, iomem_wdata, iomem_wstrb);
    end else if (tick) begin
      if (count_q == 32'd1) begin
        expire_set = 1'b1;
        count_d    = ctrl_autoreload ? reload_q : 32'd0;
      end else if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end
    end
    // Set beats a simultaneous write-one-to-clear.
    expired_d = expire_set || (expired_q && !status_w1c_0);
    irq_d     = (expired_q || captured_flag) && ctrl_irqen;
  end

  // Read mux and registered handshake; idle cycles drive rdata to zero
  always_comb begin
    ready_d = sel;
    rdata_d = 32'd0;
    if (rd) begin
      unique case (reg_idx)
        REG_CTRL:     rdata_d = {29'd0, ctrl_q};
        REG_PRESCALE: rdata_d = 32'(prescale_q);
        REG_RELOAD:   rdata_d = reload_q;
        REG_COUNT:    rdata_d = count_q;
        REG_STATUS:   rdata_d = {30'd0, captured_flag, expired_q};
        REG_CAPTURE:  rdata_d = capture_val;
        default:      rdata_d = 32'd0;
      endcase
    end
  end

  // Main register bank
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      reload_q   <= '0;
      count_q    <= '0;
      expired_q  <= 1'b0;
      pcnt_q     <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      expired_q  <= expired_d;
      pcnt_q     <= pcnt_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

`ifdef PICOSOC_IOTIMER_CAPTURE_EN
  logic        capt_meta_q, capt_sync_q, capt_prev_q;
  logic        captured_q,  captured_d;
  logic [31:0] capture_q,   capture_d;
  logic        capt_rise;

  assign capt_rise = capt_sync_q && !capt_prev_q;

  // Capture on a synchronised rising edge; set beats W1C on STATUS[1]
  always_comb begin
    capture_d  = capt_rise ? count_q : capture_q;
    captured_d = capt_rise || (captured_q && !status_w1c_1);
  end

  // Two-flop synchroniser, edge register and capture state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      capt_meta_q <= 1'b0;
      capt_sync_q <= 1'b0;
      capt_prev_q <= 1'b0;
      captured_q  <= 1'b0;
      capture_q   <= '0;
    end else begin
      capt_meta_q <= capt_in;
      capt_sync_q <= capt_meta_q;
      capt_prev_q <= capt_sync_q;
      captured_q  <= captured_d;
      capture_q   <= capture_d;
    end
  end

  assign captured_flag = captured_q;
  assign capture_val   = capture_q;
`else
  logic unused_capt;
  assign unused_capt   = capt_in ^ status_w1c_1;
  assign captured_flag = 1'b0;
  assign capture_val   = 32'd0;
`endif

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq_out     = irq_q;

endmodule

// File: tb/tb_picosoc_iotimer.sv
// Testbench for picosoc_iotimer: directed bus accesses push expected read
// data into a scoreboard; a monitor pops and compares on every iomem_ready.
module tb_picosoc_iotimer;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        irq_out;
  logic        capt_in;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   last_sel_cyc = 0;

  picosoc_iotimer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .irq_out     (irq_out),
    .capt_in     (capt_in)
  );

  always #5 clk = ~clk;

  // Edge counter used to place accesses relative to timer ticks
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding access
  always @(negedge clk) begin
    if (iomem_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", {31'd0, iomem_ready}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_read) check(e.name, iomem_rdata, e.data);
      end
    end
  end

  // One access: valid for one cycle, ready expected exactly one cycle later
  task automatic bus_xfer(input logic [31:0] off, input logic [3:0] strb,
                          input logic [31:0] wdata, input logic [31:0] exp,
                          input string name);
    exp_t e;
    @(negedge clk);
    check({name, "_rdy_idle"}, {31'd0, iomem_ready}, 32'd0);
    e.is_read = (strb == 4'b0000);
    e.data    = exp;
    e.name    = name;
    sb.push_back(e);
    iomem_valid = 1'b1;
    iomem_addr  = BASE + off;
    iomem_wstrb = strb;
    iomem_wdata = wdata;
    @(posedge clk);
    #1;
    last_sel_cyc = cyc;
    check({name, "_rdy"}, {31'd0, iomem_ready}, 32'd1);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    iomem_wdata = 32'd0;
    @(posedge clk);
    #1;
    check({name, "_rdy_drop"}, {31'd0, iomem_ready}, 32'd0);
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] wdata, input string name);
    bus_xfer(off, 4'hF, wdata, 32'd0, name);
  endtask

  task automatic bus_read(input logic [31:0] off, input logic [31:0] exp, input string name);
    bus_xfer(off, 4'h0, 32'd0, exp, name);
  endtask

  // Autoreload model, RELOAD=4, PRESCALE=0: COUNT after the k-th edge following enable
  function automatic logic [31:0] ar_count(input int k);
    return (k % 4 == 0) ? 32'd4 : 32'(4 - (k % 4));
  endfunction

  task automatic read_all_zero(input string tag);
    for (int off = 0; off <= 'h18; off += 4) begin
      bus_read(32'(off), 32'd0, $sformatf("%s_rd%02h", tag, off));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int k;
    int a_edge;
    logic [31:0] exp_capt;

    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    iomem_addr  = 32'd0;
    iomem_wdata = 32'd0;
    capt_in     = 1'b0;
    #23;
    check("rst_ready", {31'd0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_irq",   {31'd0, irq_out},     32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Every register reads zero after reset (0x18 is unmapped)
    read_all_zero("reset");

    // Byte strobes: only byte 0 of RELOAD is updated
    bus_xfer(32'h08, 4'b0001, 32'hAABB_CCDD, 32'd0, "reload_wr_b0");
    bus_read(32'h08, 32'h0000_00DD, "reload_b0");

    // Out-of-window access: never acknowledged, rdata stays zero
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0400_0000;
    iomem_wstrb = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("oow_ready_%0d", i), {31'd0, iomem_ready}, 32'd0);
      check($sformatf("oow_rdata_%0d", i), iomem_rdata, 32'd0);
    end
    iomem_valid = 1'b0;

    // One-shot: PRESCALE=3, COUNT=2 -> expiry at the 8th edge after enable
    bus_write(32'h04, 32'd3, "ps3_wr");
    bus_write(32'h0C, 32'd2, "cnt2_wr");
    bus_write(32'h00, 32'h5, "ctrl5_wr");
    repeat (7) @(posedge clk);
    #1;
    check("oneshot_irq_e8", {31'd0, irq_out}, 32'd0);
    @(posedge clk);
    #1;
    check("oneshot_irq_e9", {31'd0, irq_out}, 32'd1);
    bus_read(32'h0C, 32'd0, "oneshot_count");
    bus_read(32'h10, 32'd1, "oneshot_status");
    repeat (10) @(posedge clk);
    #1;
    bus_read(32'h0C, 32'd0, "oneshot_count_hold");

    // Autoreload, RELOAD=4, PRESCALE=0
    bus_write(32'h00, 32'h0, "ar_dis");
    bus_write(32'h10, 32'h1, "ar_w1c");
    bus_read(32'h10, 32'd0, "ar_status_clr");
    bus_write(32'h04, 32'd0, "ar_ps0");
    bus_write(32'h08, 32'd4, "ar_reload4");
    bus_write(32'h0C, 32'd4, "ar_count4");
    bus_write(32'h00, 32'h7, "ar_en");
    e0 = last_sel_cyc;
    for (int n = 0; n < 6; n++) begin
      k = cyc - e0;
      bus_read(32'h0C, ar_count(k), $sformatf("ar_count_k%0d", k));
      if (n % 2 == 1) begin
        @(posedge clk);
        #1;
      end
    end
    check("ar_irq", {31'd0, irq_out}, 32'd1);
    // W1C away from an expiry edge clears EXPIRED
    while (((cyc + 1 - e0) % 4) != 1) begin
      @(posedge clk);
      #1;
    end
    bus_write(32'h10, 32'h1, "ar_w1c_quiet");
    bus_read(32'h10, 32'd0, "ar_status_cleared");
    // W1C on the expiry edge: set wins
    while (((cyc + 1 - e0) % 4) != 0) begin
      @(posedge clk);
      #1;
    end
    bus_write(32'h10, 32'h1, "ar_w1c_collide");
    bus_read(32'h10, 32'd1, "ar_status_setwins");

    // COUNT write on a tick edge wins over the decrement
    bus_write(32'h00, 32'h0, "cw_dis");
    bus_write(32'h04, 32'd3, "cw_ps3");
    bus_write(32'h0C, 32'd50, "cw_count50");
    bus_write(32'h00, 32'h1, "cw_en");
    e0 = last_sel_cyc;
    while (((cyc + 1 - e0) % 4) != 0) begin
      @(posedge clk);
      #1;
    end
    bus_write(32'h0C, 32'd10, "cw_count10");
    bus_read(32'h0C, 32'd10, "cw_count_rd1");
    bus_read(32'h0C, 32'd10, "cw_count_rd2");
    bus_read(32'h0C, 32'd9,  "cw_count_rd3");

    // Reset in the middle of a read: ready drops at once, access discarded
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = BASE + 32'h0C;
    iomem_wstrb = 4'b0000;
    @(posedge clk);
    #1;
    check("midrst_ready_before", {31'd0, iomem_ready}, 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst_ready_after", {31'd0, iomem_ready}, 32'd0);
    check("midrst_rdata_after", iomem_rdata, 32'd0);
    check("midrst_irq_after",   {31'd0, irq_out},     32'd0);
    iomem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    read_all_zero("postrst");

`ifdef PICOSOC_IOTIMER_CAPTURE_EN
    // Capture: COUNT from 100, PRESCALE=0; CAPTURE takes COUNT at the 3rd edge
    bus_write(32'h0C, 32'd100, "cap_count100");
    bus_write(32'h00, 32'h1, "cap_en");
    e0 = last_sel_cyc;
    @(negedge clk);
    capt_in  = 1'b1;
    a_edge   = cyc + 1;
    exp_capt = 32'(100 - (a_edge + 1 - e0));
    repeat (4) @(negedge clk);
    capt_in = 1'b0;
    #1;
    bus_read(32'h14, exp_capt, "cap_value");
    bus_read(32'h10, 32'd2, "cap_status");
`else
    // Without the capture option capt_in has no effect
    bus_write(32'h0C, 32'd100, "cap_count100");
    bus_write(32'h00, 32'h1, "cap_en");
    @(negedge clk);
    capt_in = 1'b1;
    repeat (4) @(negedge clk);
    capt_in = 1'b0;
    #1;
    exp_capt = 32'd0;
    a_edge   = 0;
    bus_read(32'h14, exp_capt, "cap_off_value");
    bus_read(32'h10, 32'd0, "cap_off_status");
`endif

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
